// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth MAC.
// Operand extension keeps the recoded width even and leaves room for unsigned operands.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACC,
    DONE
  } state_t;

  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;

  function automatic int nbe(input int n);
    return (n % 2 == 0) ? n + 2 : n + 3;
  endfunction

  function automatic int iter(input int n);
    return nbe(n) / 2;
  endfunction

endpackage

// File: rtl/booth4_recode.sv
// Radix-4 Booth recoder: {b[2i+1], b[2i], b[2i-1]} to a signed digit in {0,+-1,+-2}.
// A plain +A digit is encoded with all flags clear.
module booth4_recode
  import booth_pkg::*;
(
  input  logic [2:0]   bits,
  output booth_digit_t digit
);

  always_comb begin
    digit = '0;
    unique case (bits)
      3'b000, 3'b111: digit.zero = 1'b1;
      3'b001, 3'b010: digit      = '0;
      3'b011:         digit.two  = 1'b1;
      3'b100: begin
        digit.neg = 1'b1;
        digit.two = 1'b1;
      end
      3'b101, 3'b110: digit.neg  = 1'b1;
      default:        digit      = '0;
    endcase
  end

endmodule

// File: rtl/booth4_mac.sv
// Sequential radix-4 Booth multiply-accumulate with per-operand signedness,
// valid/ready handshakes and a sticky signed-overflow accumulator.
module booth4_mac
  import booth_pkg::*;
#(
  parameter int NB    = 16,
  parameter int ACC_W = 2*NB+4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NB-1:0]     a,
  input  logic [NB-1:0]     b,
  input  logic              a_signed,
  input  logic              b_signed,
  input  logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NB-1:0]   product,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_ovf
);

  localparam int NBE  = nbe(NB);
  localparam int ITER = iter(NB);
  localparam int CW   = $clog2(ITER) + 1;
  localparam int PW   = NBE + 2;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NBE-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]     hi_q, hi_d;
  logic [NBE-1:0]    lo_q, lo_d;
  logic              bm1_q, bm1_d;
  logic              sgn_q, sgn_d;
  logic              acc_en_q, acc_en_d;
  logic [2*NB-1:0]   product_q, product_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              retire;
  logic [NBE-1:0]    a_ext, b_ext;
  booth_digit_t      digit;
  logic [PW-1:0]     mag, pp, sum;
  logic [2*NB-1:0]   prod_w;
  logic [ACC_W-1:0]  prod_ext, acc_sum;
  logic              sum_ovf;

  booth4_recode u_recode (
    .bits  ({lo_q[1:0], bm1_q}),
    .digit (digit)
  );

  assign accept = in_valid & in_ready;
  assign retire = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (cnt_q == CW'(ITER-1)) state_d = ACC;
      ACC:  state_d = DONE;
      DONE: if (retire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = out_valid_q;
    product   = product_q;
    acc       = acc_q;
    acc_ovf   = ovf_q;
  end

  always_comb begin
    a_ext = a_signed ? {{(NBE-NB){a[NB-1]}}, a}
                     : {{(NBE-NB){1'b0}}, a};
    b_ext = b_signed ? {{(NBE-NB){b[NB-1]}}, b}
                     : {{(NBE-NB){1'b0}}, b};
    mag = digit.two ? {mcand_q[NBE-1], mcand_q, 1'b0}
                    : {{2{mcand_q[NBE-1]}}, mcand_q};
    pp  = digit.zero ? '0 : (digit.neg ? ~mag + PW'(1) : mag);
    sum = hi_q + pp;
    // After ITER shifts the multiplier has fully drained out of lo_q.
    prod_w   = (2*NB)'({hi_q, lo_q});
    prod_ext = sgn_q ? ACC_W'($signed(prod_w)) : ACC_W'(prod_w);
    acc_sum  = acc_q + prod_ext;
    sum_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
  end

  always_comb begin
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    bm1_d       = bm1_q;
    sgn_d       = sgn_q;
    acc_en_d    = acc_en_q;
    product_d   = product_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = (state_q == DONE) && !retire;
    unique case (state_q)
      IDLE: if (accept) begin
        mcand_d  = a_ext;
        lo_d     = b_ext;
        hi_d     = '0;
        bm1_d    = 1'b0;
        cnt_d    = '0;
        sgn_d    = a_signed | b_signed;
        acc_en_d = acc_en;
      end
      BUSY: begin
        hi_d  = {{2{sum[PW-1]}}, sum[PW-1:2]};
        lo_d  = {sum[1:0], lo_q[NBE-1:2]};
        bm1_d = lo_q[1];
        cnt_d = cnt_q + CW'(1);
      end
      ACC: begin
        product_d = prod_w;
        if (acc_en_q) begin
          acc_d = acc_sum;
          ovf_d = ovf_q | sum_ovf;
        end else begin
          acc_d = prod_ext;
          ovf_d = 1'b0;
        end
      end
      DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      mcand_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      bm1_q       <= 1'b0;
      sgn_q       <= 1'b0;
      acc_en_q    <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      bm1_q       <= bm1_d;
      sgn_q       <= sgn_d;
      acc_en_q    <= acc_en_d;
      product_q   <= product_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_booth4_mac.sv
// Directed bench for booth4_mac at NB=8, ACC_W=20.
// Each scenario task drives its own stimulus and checks hand-computed results.
module tb_booth4_mac;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        a_signed;
  logic        b_signed;
  logic        acc_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [19:0] acc;
  logic        acc_ovf;

  int tests;
  int fails;

  booth4_mac #(.NB(8), .ACC_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .acc       (acc),
    .acc_ovf   (acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Starts one op from IDLE; lat = edges from accept to out_valid, -1 on timeout.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb,
                       input logic tas, input logic tbs, input logic tae,
                       output int lat);
    a = ta; b = tb; a_signed = tas; b_signed = tbs; acc_en = tae;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'h00; b = 8'h00;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (product !== 16'h0000) begin fails++; $display("FAIL reset_product: got %h want 0000", product); end
    tests++; if (acc !== 20'h00000) begin fails++; $display("FAIL reset_acc: got %h want 00000", acc); end
    tests++; if (acc_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", acc_ovf); end
  endtask

  task automatic test_signed_min();
    int lat;
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, lat);
    tests++; if (lat != 7) begin fails++; $display("FAIL min_latency: got %0d want 7", lat); end
    tests++; if (product !== 16'h4000) begin fails++; $display("FAIL min_product: got %h want 4000", product); end
    tests++; if (acc !== 20'h04000) begin fails++; $display("FAIL min_acc: got %h want 04000", acc); end
    tests++; if (acc_ovf !== 1'b0) begin fails++; $display("FAIL min_ovf: got %b want 0", acc_ovf); end
    retire();
  endtask

  task automatic test_modes();
    int lat;
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, lat);
    tests++; if (product !== 16'hFE01) begin fails++; $display("FAIL uu_product: got %h want fe01", product); end
    tests++; if (acc !== 20'h0FE01) begin fails++; $display("FAIL uu_acc: got %h want 0fe01", acc); end
    retire();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, lat);
    tests++; if (product !== 16'hFF01) begin fails++; $display("FAIL su_product: got %h want ff01", product); end
    tests++; if (acc !== 20'hFFF01) begin fails++; $display("FAIL su_acc: got %h want fff01", acc); end
    retire();
    do_op(8'h05, 8'hFF, 1'b0, 1'b1, 1'b0, lat);
    tests++; if (product !== 16'hFFFB) begin fails++; $display("FAIL us_product: got %h want fffb", product); end
    retire();
  endtask

  task automatic test_accumulate();
    int lat;
    do_op(8'h03, 8'h04, 1'b1, 1'b1, 1'b0, lat);
    tests++; if (acc !== 20'h0000C) begin fails++; $display("FAIL acc_load: got %h want 0000c", acc); end
    retire();
    do_op(8'h05, 8'hFE, 1'b1, 1'b1, 1'b1, lat);
    tests++; if (product !== 16'hFFF6) begin fails++; $display("FAIL acc_product: got %h want fff6", product); end
    tests++; if (acc !== 20'h00002) begin fails++; $display("FAIL acc_sum: got %h want 00002", acc); end
    tests++; if (acc_ovf !== 1'b0) begin fails++; $display("FAIL acc_ovf: got %b want 0", acc_ovf); end
    retire();
  endtask

  task automatic test_overflow();
    int lat;
    logic exp_ovf;
    do_op(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, lat);
    tests++; if (acc !== 20'h00000) begin fails++; $display("FAIL ovf_clear: got %h want 00000", acc); end
    retire();
    for (int k = 1; k <= 32; k++) begin
      do_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, lat);
      exp_ovf = (k >= 32);
      tests++; if (acc_ovf !== exp_ovf) begin fails++; $display("FAIL ovf_step%0d: got %b want %b", k, acc_ovf, exp_ovf); end
      if (k == 31) begin
        tests++; if (acc !== 20'h7C000) begin fails++; $display("FAIL ovf_acc31: got %h want 7c000", acc); end
      end
      if (k == 32) begin
        tests++; if (acc !== 20'h80000) begin fails++; $display("FAIL ovf_acc32: got %h want 80000", acc); end
      end
      retire();
    end
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, lat);
    tests++; if (acc !== 20'h84000) begin fails++; $display("FAIL ovf_acc33: got %h want 84000", acc); end
    tests++; if (acc_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", acc_ovf); end
    retire();
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, lat);
    tests++; if (acc_ovf !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %b want 0", acc_ovf); end
    tests++; if (acc !== 20'h04000) begin fails++; $display("FAIL ovf_reload: got %h want 04000", acc); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    do_op(8'h07, 8'h09, 1'b0, 1'b0, 1'b0, lat);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        a = 8'h01; b = 8'h01; acc_en = 1'b1; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          product !== 16'h003F || acc !== 20'h0003F) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    retire();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_retired: got %b want 0", out_valid); end
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_no_accept: got in_ready %b want 1", in_ready); end
    do_op(8'h02, 8'h03, 1'b0, 1'b0, 1'b1, lat);
    tests++; if (acc !== 20'h00045) begin fails++; $display("FAIL bp_next_acc: got %h want 00045", acc); end
    retire();
  endtask

  task automatic test_reset_busy();
    int lat;
    int seen;
    a = 8'h05; b = 8'h05; a_signed = 1'b0; b_signed = 1'b0; acc_en = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rb_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rb_out_valid: got %b want 0", out_valid); end
    tests++; if (product !== 16'h0000) begin fails++; $display("FAIL rb_product: got %h want 0000", product); end
    tests++; if (acc !== 20'h00000) begin fails++; $display("FAIL rb_acc: got %h want 00000", acc); end
    tests++; if (acc_ovf !== 1'b0) begin fails++; $display("FAIL rb_ovf: got %b want 0", acc_ovf); end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rb_stale: got %0d valid cycles want 0", seen); end
    do_op(8'h07, 8'h09, 1'b0, 1'b0, 1'b0, lat);
    tests++; if (lat != 7) begin fails++; $display("FAIL rb_latency: got %0d want 7", lat); end
    tests++; if (product !== 16'h003F) begin fails++; $display("FAIL rb_product2: got %h want 003f", product); end
    tests++; if (acc !== 20'h0003F) begin fails++; $display("FAIL rb_acc2: got %h want 0003f", acc); end
    retire();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    a_signed = 1'b0;
    b_signed = 1'b0;
    acc_en = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_signed_min();
    test_modes();
    test_accumulate();
    test_overflow();
    test_backpressure();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
